uart_loopback_buffer: RTL and testbench
=======================================

# uart_loopback_buffer

Parametrised loopback core for the FPGA UART designs. It sits between the UART receiver byte stream and the UART transmitter byte stream. Received words go into a FIFO of configurable width and depth. The FIFO is drained to the transmitter in one of three modes: direct echo, ASCII case-swap echo, or line-buffered echo. Overflow is counted so that software or ILA can read back dropped traffic.

## Interface
Parameters:
- DATA_WIDTH, 8: word width of the RX/TX streams.
- DEPTH, 16: FIFO depth in words; must be a power of 2 and ≥ 2.
- OVF_CNT_W, 8: width of the saturating overflow counter.

Ports:
- clk  in  1: system clock; the block uses this single clock.
- rst  in  1: reset, synchronous, active-high.
- mode  in  2: 0 = echo, 1 = line-buffered, 2 = case-swap echo, 3 = treated as 0.
- rx_valid  in  1: one-cycle strobe; rx_data is valid in that cycle. The receiver cannot stall.
- rx_data  in  DATA_WIDTH: received word.
- tx_valid  out  1: tx_data is valid.
- tx_data  out  DATA_WIDTH: word to transmit.
- tx_ready  in  1: the transmitter accepts the word. A transfer happens when tx_valid && tx_ready.
- fifo_count  out  $clog2(DEPTH+1): current occupancy.
- overflow  out  1: one-cycle pulse when a word is dropped.
- overflow_cnt  out  OVF_CNT_W: count of dropped words; saturates at all-ones.

## Operation
- **FIFO structure:** circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a separate count register.
- **Push:** occurs when rx_valid && (count < DEPTH || pop in the same cycle).
- **Drop:** if rx_valid arrives with count == DEPTH and no pop that cycle, the word is dropped, overflow pulses, and overflow_cnt increments (saturating).
- **Simultaneous push and pop:** count is unchanged. This is legal at both full and empty.
- **Output data:** tx_data = xform(mem[rd_ptr]). Words are not re-registered at the output, so tx_data is stable while tx_valid && !tx_ready.
- **xform in mode 2 with DATA_WIDTH == 8:** bytes 0x41–0x5A and 0x61–0x7A have bit 5 inverted; all other bytes pass unchanged.
- **xform otherwise:** identity. This includes mode 2 when DATA_WIDTH != 8.
- **Mode latching:**
  - The mode input is captured into act_mode only in a cycle where count == 0 and no push occurs.
  - Otherwise act_mode holds its value.
  - act_mode resets to 0.
- **Echo modes (act_mode 0/2):** tx_valid = (count != 0).
- **Line mode (act_mode 1), state machine FILL / DRAIN:**
  - **FILL:** tx_valid = 0. Go to DRAIN next cycle when either:
    - a pushed word equals 0x0A (compared on the low 8 bits; the full word when DATA_WIDTH < 8), or
    - count becomes DEPTH.
    - On that transition, drain_cnt is loaded with the post-push count.
  - **DRAIN:** tx_valid = (drain_cnt != 0). Each pop decrements drain_cnt. When drain_cnt reaches 0, return to FILL.
  - Words pushed during DRAIN stay queued for the next FILL evaluation.
  - **Re-trigger on entering FILL:** if a queued word is 0x0A, or count == DEPTH, DRAIN is re-entered on the next cycle. The block scans by count only, so a queued LF re-triggers DRAIN in the next FILL cycle whenever count > 0 and the LF is in the queue. Implementation: keep lf_pending = number of LFs in the FIFO, width $clog2(DEPTH+1).
  - While act_mode != 1 the state is held at FILL.
- **Reset:** rst is sampled synchronously. It clears pointers, count, drain_cnt, lf_pending, overflow_cnt and act_mode, and sets the state to FILL.

## Timing
- **Reset values:**
  - tx_valid = 0, fifo_count = 0, overflow = 0, overflow_cnt = 0.
  - tx_data = xform(mem[0]), which is undefined content.
- **Echo latency:** rx_valid in cycle N → tx_valid = 1 in cycle N+1 with that word. A pop in cycle M presents the next word in cycle M+1.
- **Line latency:** LF pushed in cycle N → state DRAIN and tx_valid = 1 in cycle N+1.
- **overflow pulse:** asserted in the cycle after the dropped rx_valid. overflow_cnt updates in the same cycle.
- **fifo_count:** updates in the cycle after each push or pop.
- **Reset mid-operation:**
  - Contents are discarded; the next cycle shows tx_valid = 0.
  - An rx_valid during the rst cycle is ignored.

## Test plan
- **Mode 0 echo with stall:** push 0x55, 0xAA, 0x0F with tx_ready = 0 → fifo_count = 3. Then raise tx_ready → tx_data sequence 0x55, 0xAA, 0x0F, then tx_valid = 0 and fifo_count = 0.
- **Mode 2 case-swap:** push "aZ1" (0x61, 0x5A, 0x31) → tx_data 0x41, 0x7A, 0x31.
- **Mode 1 line buffering:**
  - Push "hi" → tx_valid stays 0 for 20 cycles.
  - Push 0x0A → in the next cycle tx_valid = 1. Drains 0x68, 0x69, 0x0A, then tx_valid = 0.
  - A byte 0x41 pushed mid-drain remains queued (fifo_count = 1).
- **Overflow, DEPTH = 16, tx_ready = 0:**
  - Push 18 words → fifo_count = 16, overflow pulses twice, overflow_cnt = 2.
  - Words 1–16 are delivered in order.
  - With OVF_CNT_W = 2, pushing 5 extra words leaves overflow_cnt = 3.
- **Full with simultaneous push/pop:** FIFO full, rx_valid and tx_ready in the same cycle → no overflow, fifo_count stays 16, order preserved.
- **Mode change and reset:**
  - Change mode 0→1 while 3 words are queued → they echo under mode 0, and mode 1 applies after empty.
  - Assert rst mid-drain → next cycle tx_valid = 0, fifo_count = 0, overflow_cnt = 0.

Source files
------------

// File: rtl/uart_loopback_buffer.sv
// uart_loopback_buffer: FIFO between the UART RX and TX byte streams.
// Drains in plain echo, ASCII case-swap echo, or line-buffered mode.
// Dropped words are pulsed on overflow and tallied in a saturating counter.
module uart_loopback_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int OVF_CNT_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   mode,
   input  logic                         rx_valid,
   input  logic [DATA_WIDTH-1:0]        rx_data,
   output logic                         tx_valid,
   output logic [DATA_WIDTH-1:0]        tx_data,
   input  logic                         tx_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         overflow,
   output logic [OVF_CNT_W-1:0]         overflow_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] MODE_ECHO = 2'd0;
   localparam logic [1:0] MODE_LINE = 2'd1;
   localparam logic [1:0] MODE_SWAP = 2'd2;

   typedef enum logic {FILL, DRAIN} state_e;

   // Line feed detection looks at the low byte; narrower words compare whole.
   function automatic logic is_lf(input logic [DATA_WIDTH-1:0] w);
      return (w & DATA_WIDTH'(8'hFF)) == DATA_WIDTH'(8'h0A);
   endfunction

   // Case swap only exists for byte-wide streams; everything else passes through.
   function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] w,
                                                   input logic [1:0] am);
      logic [DATA_WIDTH-1:0] r;
      logic                  alpha;
      r     = w;
      alpha = ((w >= DATA_WIDTH'(8'h41)) && (w <= DATA_WIDTH'(8'h5A))) ||
              ((w >= DATA_WIDTH'(8'h61)) && (w <= DATA_WIDTH'(8'h7A)));
      if ((DATA_WIDTH == 8) && (am == MODE_SWAP) && alpha)
         r = w ^ DATA_WIDTH'(8'h20);
      return r;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         lf_pending_q, lf_pending_d;
   logic [CW-1:0]         drain_cnt_q, drain_cnt_d;
   logic [1:0]            act_mode_q, act_mode_d;
   logic                  overflow_q, overflow_d;
   logic [OVF_CNT_W-1:0]  overflow_cnt_q, overflow_cnt_d;
   state_e                state_q, state_d;

   logic                  push;
   logic                  pop;
   logic                  drop;
   logic [DATA_WIDTH-1:0] head;

   assign head = mem_q[rd_ptr_q];

   // FIFO bookkeeping, mode capture and overflow accounting.
   always_comb begin
      pop  = tx_valid && tx_ready;
      push = rx_valid && ((count_q != FULL) || pop);
      drop = rx_valid && (count_q == FULL) && !pop;

      rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      lf_pending_d = lf_pending_q + CW'(push && is_lf(rx_data)) - CW'(pop && is_lf(head));

      act_mode_d = act_mode_q;
      if ((count_q == '0) && !push)
         act_mode_d = (mode == 2'd3) ? MODE_ECHO : mode;

      overflow_d     = drop;
      overflow_cnt_d = overflow_cnt_q;
      if (drop && (overflow_cnt_q != '1))
         overflow_cnt_d = overflow_cnt_q + OVF_CNT_W'(1);
   end

   // Line-mode sequencing: hold words until a line feed or a full FIFO, then drain that many.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      if (act_mode_q != MODE_LINE) begin
         state_d     = FILL;
         drain_cnt_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               if ((push && is_lf(rx_data)) || (lf_pending_q != '0) || (count_d == FULL)) begin
                  state_d     = DRAIN;
                  drain_cnt_d = count_d;
               end
            end
            DRAIN: begin
               drain_cnt_d = drain_cnt_q - CW'(pop);
               if (drain_cnt_d == '0)
                  state_d = FILL;
            end
            default: state_d = FILL;
         endcase
      end
   end

   // Transmit side: echo modes show any queued word, line mode only while draining.
   always_comb begin
      tx_valid = 1'b0;
      if (act_mode_q == MODE_LINE)
         tx_valid = (state_q == DRAIN) && (drain_cnt_q != '0);
      else
         tx_valid = (count_q != '0);
      tx_data = xform(head, act_mode_q);
   end

   // Line-mode state register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= FILL;
      else
         state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         lf_pending_q   <= '0;
         drain_cnt_q    <= '0;
         act_mode_q     <= MODE_ECHO;
         overflow_q     <= 1'b0;
         overflow_cnt_q <= '0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         lf_pending_q   <= lf_pending_d;
         drain_cnt_q    <= drain_cnt_d;
         act_mode_q     <= act_mode_d;
         overflow_q     <= overflow_d;
         overflow_cnt_q <= overflow_cnt_d;
      end
   end

   // Storage array; contents are not cleared by reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem_q[wr_ptr_q] <= rx_data;
   end

   assign fifo_count   = count_q;
   assign overflow     = overflow_q;
   assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// tb_uart_loopback_buffer: directed checks of echo, case swap, line mode,
// overflow, full push/pop, mode latching and reset behaviour.
module tb_uart_loopback_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [4:0] fifo_count;
   logic       overflow;
   logic [7:0] overflow_cnt;

   logic       rx_valid2;
   logic [7:0] rx_data2;
   logic       tx_valid2;
   logic [7:0] tx_data2;
   logic [4:0] fifo_count2;
   logic       overflow2;
   logic [1:0] overflow_cnt2;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   uart_loopback_buffer #(.DATA_WIDTH(8), .DEPTH(16), .OVF_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .fifo_count(fifo_count), .overflow(overflow), .overflow_cnt(overflow_cnt)
   );

   uart_loopback_buffer #(.DATA_WIDTH(8), .DEPTH(16), .OVF_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .mode(2'd0), .rx_valid(rx_valid2), .rx_data(rx_data2),
      .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(1'b0),
      .fifo_count(fifo_count2), .overflow(overflow2), .overflow_cnt(overflow_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      rx_valid = v;
      rx_data  = d;
      tx_ready = r;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 2'd0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      tx_ready  = 1'b0;
      rx_valid2 = 1'b0;
      rx_data2  = 8'h00;
      tick();
      tick();
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_fifo_count", fifo_count, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_overflow_cnt", overflow_cnt, 0);
      rst = 1'b0;

      // Mode 0 echo with stall
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("echo_latency_valid", tx_valid, 1);
      checkOutput("echo_latency_data", tx_data, 8'h55);
      applyStimulus(1'b1, 8'hAA, 1'b0);
      applyStimulus(1'b1, 8'h0F, 1'b0);
      checkOutput("echo_count3", fifo_count, 3);
      checkOutput("echo_stall_data", tx_data, 8'h55);
      checkOutput("echo_head0", tx_data, 8'h55);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("echo_head1", tx_data, 8'hAA);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("echo_head2", tx_data, 8'h0F);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("echo_empty_valid", tx_valid, 0);
      checkOutput("echo_empty_count", fifo_count, 0);

      // Mode 2 case swap
      mode = 2'd2;
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h61, 1'b0);
      applyStimulus(1'b1, 8'h5A, 1'b0);
      applyStimulus(1'b1, 8'h31, 1'b0);
      checkOutput("swap_a", tx_data, 8'h41);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("swap_Z", tx_data, 8'h7A);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("swap_1", tx_data, 8'h31);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("swap_empty", tx_valid, 0);

      // Mode 1 line buffering
      mode = 2'd1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h68, 1'b1);
      applyStimulus(1'b1, 8'h69, 1'b1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("line_hold_valid", tx_valid, 0);
      end
      checkOutput("line_hold_count", fifo_count, 2);
      applyStimulus(1'b1, 8'h0A, 1'b1);
      checkOutput("line_lf_valid", tx_valid, 1);
      checkOutput("line_drain_h", tx_data, 8'h68);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("line_drain_i", tx_data, 8'h69);
      applyStimulus(1'b1, 8'h41, 1'b1);
      checkOutput("line_drain_lf", tx_data, 8'h0A);
      checkOutput("line_mid_count", fifo_count, 2);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("line_done_valid", tx_valid, 0);
      checkOutput("line_queued_count", fifo_count, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("line_queued_hold", tx_valid, 0);
      end
      applyStimulus(1'b1, 8'h0A, 1'b1);
      checkOutput("line_flush_A", tx_data, 8'h41);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("line_flush_lf", tx_data, 8'h0A);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("line_flush_valid", tx_valid, 0);
      checkOutput("line_flush_count", fifo_count, 0);

      // Overflow with the transmitter stalled
      mode = 2'd0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b1, 8'(i + 1), 1'b0);
         checkOutput("ovf_pulse", overflow, (i >= 16) ? 1 : 0);
      end
      checkOutput("ovf_count_full", fifo_count, 16);
      checkOutput("ovf_cnt2", overflow_cnt, 2);
      checkOutput("ovf_head", tx_data, 8'h01);

      // Full FIFO with simultaneous push and pop
      applyStimulus(1'b1, 8'h99, 1'b1);
      checkOutput("fullpp_overflow", overflow, 0);
      checkOutput("fullpp_count", fifo_count, 16);
      for (int k = 2; k <= 16; k++) begin
         checkOutput("fullpp_order", tx_data, k);
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkOutput("fullpp_last", tx_data, 8'h99);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("fullpp_empty", tx_valid, 0);
      checkOutput("fullpp_cnt_kept", overflow_cnt, 2);

      // Saturating counter on the narrow instance
      for (int i = 0; i < 21; i++) begin
         rx_valid2 = 1'b1;
         rx_data2  = 8'(i);
         tick();
      end
      rx_valid2 = 1'b0;
      tick();
      checkOutput("sat_count", fifo_count2, 16);
      checkOutput("sat_ovf_cnt", overflow_cnt2, 3);

      // Mode change while words are queued
      applyStimulus(1'b1, 8'h11, 1'b0);
      mode = 2'd1;
      applyStimulus(1'b1, 8'h22, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0);
      checkOutput("mchg_valid", tx_valid, 1);
      checkOutput("mchg_count", fifo_count, 3);
      checkOutput("mchg_w0", tx_data, 8'h11);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("mchg_w1", tx_data, 8'h22);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("mchg_w2", tx_data, 8'h33);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("mchg_empty", tx_valid, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h44, 1'b1);
      checkOutput("mchg_line_hold", tx_valid, 0);
      checkOutput("mchg_line_count", fifo_count, 1);
      applyStimulus(1'b1, 8'h0A, 1'b0);
      checkOutput("mchg_line_drain", tx_valid, 1);
      checkOutput("mchg_line_data", tx_data, 8'h44);

      // Reset in the middle of a drain, with a word arriving during reset
      rst  = 1'b1;
      mode = 2'd0;
      applyStimulus(1'b1, 8'h55, 1'b1);
      rst = 1'b0;
      checkOutput("midrst_valid", tx_valid, 0);
      checkOutput("midrst_count", fifo_count, 0);
      checkOutput("midrst_ovf_cnt", overflow_cnt, 0);
      checkOutput("midrst_overflow", overflow, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("midrst_rx_ignored", fifo_count, 0);
      applyStimulus(1'b1, 8'h5B, 1'b0);
      checkOutput("postrst_echo_valid", tx_valid, 1);
      checkOutput("postrst_echo_data", tx_data, 8'h5B);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
